// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl
// Direct-mapped, write-back, write-allocate data cache controller for the MEM
// stage. Loads that hit return data in the same cycle. Stores that hit update
// the line at the clock edge and mark it dirty. A miss raises stall_o, writes
// back the victim line if it is dirty, and then fills the line from the
// line-wide backing memory.
//
// Ports
//   clk_i, rst_i            clock (rising edge), asynchronous active-high reset
//   cpu_req_i / cpu_we_i    access request, 1 = store / 0 = load
//   cpu_addr_i              byte address (bits [1:0] ignored)
//   cpu_wdata_i             store data
//   cpu_rdata_o             load data (combinational on a load hit, else 0)
//   stall_o                 pipeline freeze while a miss is serviced
//   mem_req_o / mem_we_o    backing memory request, 1 = write-back / 0 = fill
//   mem_addr_o              line-aligned backing memory address
//   mem_wdata_o             write-back line data
//   mem_rdata_i             fill line data, valid with mem_ack_i
//   mem_ack_i               single-cycle completion pulse
// -----------------------------------------------------------------------------
module dcache_ctrl #(
    parameter int NUM_LINES  = 32,
    parameter int LINE_BYTES = 32,
    parameter int ADDR_W     = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cpu_req_i,
    input  logic                    cpu_we_i,
    input  logic [ADDR_W-1:0]       cpu_addr_i,
    input  logic [31:0]             cpu_wdata_i,
    output logic [31:0]             cpu_rdata_o,
    output logic                    stall_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic [8*LINE_BYTES-1:0] mem_wdata_o,
    input  logic [8*LINE_BYTES-1:0] mem_rdata_i,
    input  logic                    mem_ack_i
);
    localparam int INDEX_W  = $clog2(NUM_LINES);
    localparam int OFFSET_W = $clog2(LINE_BYTES);
    localparam int LINE_W   = 8 * LINE_BYTES;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WORD_W   = OFFSET_W - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_ALLOCATE
    } state_t;

    // Address split of the live CPU request.
    logic [TAG_W-1:0]   cpu_tag;
    logic [INDEX_W-1:0] cpu_index;
    logic [WORD_W-1:0]  cpu_word;

    assign cpu_tag   = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign cpu_index = cpu_addr_i[OFFSET_W +: INDEX_W];
    assign cpu_word  = cpu_addr_i[2 +: WORD_W];

    // Byte-lane bits never select anything; name them so lint sees them used.
    logic unused_byte_bits;
    assign unused_byte_bits = ^cpu_addr_i[1:0];

    // Line storage: valid/dirty reset, tag/data deliberately not reset.
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    line_q [NUM_LINES];

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;

    // Single write port into the line/tag arrays, always at cpu_index.
    logic                line_wr_en;
    logic [LINE_W-1:0]   line_d;
    logic                tag_wr_en;

    logic [LINE_W-1:0]   cur_line;
    logic [TAG_W-1:0]    cur_tag;
    logic [31:0]         cur_word;
    logic                hit;

    assign cur_line = line_q[cpu_index];
    assign cur_tag  = tag_q[cpu_index];
    assign cur_word = cur_line[{cpu_word, 5'b00000} +: 32];
    assign hit      = cpu_req_i & valid_q[cpu_index] & (cur_tag == cpu_tag);

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        line_wr_en  = 1'b0;
        line_d      = cur_line;
        tag_wr_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_req_i) begin
                    if (hit) begin
                        if (cpu_we_i) begin
                            line_wr_en = 1'b1;
                            line_d[{cpu_word, 5'b00000} +: 32] = cpu_wdata_i;
                            dirty_d[cpu_index] = 1'b1;
                        end
                    end else if (valid_q[cpu_index] && dirty_q[cpu_index]) begin
                        // Victim is dirty: push it out before the fill.
                        state_d     = S_WRITEBACK;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {cur_tag, cpu_index, {OFFSET_W{1'b0}}};
                        mem_wdata_d = cur_line;
                    end else begin
                        state_d    = S_ALLOCATE;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {cpu_tag, cpu_index, {OFFSET_W{1'b0}}};
                    end
                end
            end
            S_WRITEBACK: begin
                if (mem_ack_i) begin
                    dirty_d[cpu_index] = 1'b0;
                    state_d    = S_ALLOCATE;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {cpu_tag, cpu_index, {OFFSET_W{1'b0}}};
                end
            end
            S_ALLOCATE: begin
                if (mem_ack_i) begin
                    // The access itself completes as a hit in the next IDLE cycle.
                    state_d            = S_IDLE;
                    mem_req_d          = 1'b0;
                    line_wr_en         = 1'b1;
                    line_d             = mem_rdata_i;
                    tag_wr_en          = 1'b1;
                    valid_d[cpu_index] = 1'b1;
                    dirty_d[cpu_index] = 1'b0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (line_wr_en) begin
            line_q[cpu_index] <= line_d;
        end
        if (tag_wr_en) begin
            tag_q[cpu_index] <= cpu_tag;
        end
    end

    // CPU-side outputs are combinational; they are forced quiet while reset
    // is asserted so an aborted miss releases the pipeline at once.
    assign stall_o     = ~rst_i & ((state_q != S_IDLE) | (cpu_req_i & ~hit));
    assign cpu_rdata_o = (~rst_i && state_q == S_IDLE && hit && !cpu_we_i) ? cur_word : 32'h0;

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcache_ctrl
// Self-checking bench for dcache_ctrl. The reference model views memory as a
// flat word store (latest value written to each address) plus a per-index
// residency record used to predict hit/miss and the write-back traffic. The
// bench also plays the backing memory, answering requests after a chosen delay.
// -----------------------------------------------------------------------------
module tb_dcache_ctrl;
    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_wdata_i;
    logic [31:0]  cpu_rdata_o;
    logic         stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic [255:0] mem_rdata_i;
    logic         mem_ack_i;

    dcache_ctrl dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    logic [31:0] bmem [logic [31:0]];   // backing memory, word granular
    logic [31:0] wmem [logic [31:0]];   // latest architectural value per word
    bit          res_valid [32];
    bit          res_dirty [32];
    logic [31:0] res_la    [32];
    logic [31:0] last_wb_addr;
    logic [255:0] last_wb_data;
    int          wb_count = 0;

    function automatic logic [31:0] gen_word(input logic [31:0] a);
        if (a == 32'h0000_0104) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] bmem_word(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return gen_word(a);
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        if (wmem.exists(a)) return wmem[a];
        return bmem_word(a);
    endfunction

    // Reset loses every dirty line still held in the cache.
    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            if (res_valid[i] && res_dirty[i]) begin
                for (int w = 0; w < 8; w++) wmem[res_la[i] + 32'(4 * w)] = bmem_word(res_la[i] + 32'(4 * w));
            end
            res_valid[i] = 1'b0;
            res_dirty[i] = 1'b0;
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkl(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One CPU access, including any miss handling, checked cycle by cycle.
    task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                             input int delay, output bit hit_o, output logic [31:0] rdata_o);
        logic [31:0]  la;
        logic [31:0]  wa;
        logic [31:0]  old_la;
        logic [255:0] line;
        int           idx;
        bit           exp_hit;
        la  = {addr[31:5], 5'b0};
        wa  = {addr[31:2], 2'b0};
        idx = int'(addr[9:5]);
        @(negedge clk_i);
        cpu_req_i   = 1'b1;
        cpu_we_i    = we;
        cpu_addr_i  = addr;
        cpu_wdata_i = wdata;
        #1;
        exp_hit = res_valid[idx] && (res_la[idx] == la);
        hit_o   = !stall_o;
        chk1("first_cycle_stall", stall_o, !exp_hit);
        if (!exp_hit) begin
            if (res_valid[idx] && res_dirty[idx]) begin
                old_la = res_la[idx];
                for (int w = 0; w < 8; w++) line[w*32 +: 32] = exp_word(old_la + 32'(4 * w));
                @(negedge clk_i);
                chk1("wb_we", mem_we_o, 1'b1);
                chk32("wb_addr", mem_addr_o, old_la);
                chkl("wb_data", mem_wdata_o, line);
                for (int d = 0; d <= delay; d++) begin
                    if (d > 0) @(negedge clk_i);
                    chk1("wb_req", mem_req_o, 1'b1);
                    chk1("wb_stall", stall_o, 1'b1);
                    chk32("wb_addr_hold", mem_addr_o, old_la);
                end
                last_wb_addr = mem_addr_o;
                last_wb_data = mem_wdata_o;
                wb_count++;
                for (int w = 0; w < 8; w++) bmem[old_la + 32'(4 * w)] = mem_wdata_o[w*32 +: 32];
                mem_ack_i = 1'b1;
                @(negedge clk_i);
                mem_ack_i = 1'b0;
                res_dirty[idx] = 1'b0;
            end else begin
                @(negedge clk_i);
            end
            chk1("fill_we", mem_we_o, 1'b0);
            for (int w = 0; w < 8; w++) line[w*32 +: 32] = bmem_word(la + 32'(4 * w));
            mem_rdata_i = line;
            for (int d = 0; d <= delay; d++) begin
                if (d > 0) @(negedge clk_i);
                chk1("fill_req", mem_req_o, 1'b1);
                chk1("fill_stall", stall_o, 1'b1);
                chk32("fill_addr", mem_addr_o, la);
            end
            mem_ack_i = 1'b1;
            @(negedge clk_i);
            mem_ack_i   = 1'b0;
            mem_rdata_i = '0;
            chk1("fill_req_drop", mem_req_o, 1'b0);
            chk1("post_fill_stall", stall_o, 1'b0);
            res_valid[idx] = 1'b1;
            res_la[idx]    = la;
            res_dirty[idx] = 1'b0;
        end
        rdata_o = cpu_rdata_o;
        if (!we) begin
            chk32("load_data", cpu_rdata_o, exp_word(wa));
        end else begin
            wmem[wa]       = wdata;
            res_dirty[idx] = 1'b1;
        end
        @(posedge clk_i);
    endtask

    // Idle cycle with a stray ack pulse, which must be ignored.
    task automatic idle_ack();
        @(negedge clk_i);
        cpu_req_i = 1'b0;
        mem_ack_i = 1'b1;
        #1;
        chk1("idle_stall", stall_o, 1'b0);
        chk32("idle_rdata", cpu_rdata_o, 32'h0);
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        chk1("idle_req", mem_req_o, 1'b0);
        chk1("idle_stall2", stall_o, 1'b0);
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        bit          exp_hit;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bit          h;
        logic [31:0] r;
        logic [31:0] a;
        int          wb_before;

        for (int i = 0; i < 32; i++) begin
            res_valid[i] = 1'b0;
            res_dirty[i] = 1'b0;
            res_la[i]    = '0;
        end
        rst_i       = 1'b1;
        cpu_req_i   = 1'b0;
        cpu_we_i    = 1'b0;
        cpu_addr_i  = '0;
        cpu_wdata_i = '0;
        mem_rdata_i = '0;
        mem_ack_i   = 1'b0;
        #1;
        chk1("rst_req", mem_req_o, 1'b0);
        chk1("rst_we", mem_we_o, 1'b0);
        chk32("rst_addr", mem_addr_o, 32'h0);
        chkl("rst_wdata", mem_wdata_o, 256'h0);
        chk32("rst_rdata", cpu_rdata_o, 32'h0);
        chk1("rst_stall", stall_o, 1'b0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        vecs[0] = '{1'b0, 32'h0000_0104, 32'h0,         2,  1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 32'h0000_0108, 32'h1234_5678, 0,  1'b1, 32'h0};
        vecs[2] = '{1'b0, 32'h0000_0108, 32'h0,         0,  1'b1, 32'h1234_5678};
        vecs[3] = '{1'b0, 32'h0000_0508, 32'h0,         1,  1'b0, gen_word(32'h0000_0508)};
        vecs[4] = '{1'b0, 32'h0000_0104, 32'h0,         10, 1'b0, 32'hDEAD_BEEF};
        vecs[5] = '{1'b0, 32'h0000_0100, 32'h0,         0,  1'b1, gen_word(32'h0000_0100)};

        for (int i = 0; i < 6; i++) begin
            wb_before = wb_count;
            do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].delay, h, r);
            chk1($sformatf("vec%0d_hit", i), h, vecs[i].exp_hit);
            if (!vecs[i].we) chk32($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rdata);
            if (i == 3) begin
                chk32("evict_wb_addr", last_wb_addr, 32'h0000_0100);
                chk32("evict_wb_word2", last_wb_data[64 +: 32], 32'h1234_5678);
            end
            if (i == 4) chk32("no_rewriteback", 32'(wb_count - wb_before), 32'h0);
        end

        // Stray ack while idle must leave the resident line untouched.
        idle_ack();
        do_access(1'b0, 32'h0000_0104, 32'h0, 0, h, r);
        chk1("after_idle_ack_hit", h, 1'b1);
        chk32("after_idle_ack_data", r, 32'hDEAD_BEEF);

        // Reset while a write-back is outstanding.
        do_access(1'b1, 32'h0000_0104, 32'hCAFE_F00D, 0, h, r);
        chk1("dirtying_store_hit", h, 1'b1);
        @(negedge clk_i);
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0000_0504;
        #1;
        chk1("rst_case_miss_stall", stall_o, 1'b1);
        @(negedge clk_i);
        chk1("rst_case_wb_req", mem_req_o, 1'b1);
        chk1("rst_case_wb_we", mem_we_o, 1'b1);
        #2;
        rst_i = 1'b1;
        #1;
        chk1("rst_case_req_drop", mem_req_o, 1'b0);
        chk1("rst_case_stall_drop", stall_o, 1'b0);
        model_reset();
        @(negedge clk_i);
        rst_i     = 1'b0;
        cpu_req_i = 1'b0;
        do_access(1'b0, 32'h0000_0104, 32'h0, 1, h, r);
        chk1("reload_after_rst_hit", h, 1'b0);
        chk32("reload_after_rst_data", r, 32'hDEAD_BEEF);

        // Two resident lines, then 16 back-to-back loads with no stall.
        do_access(1'b0, 32'h0000_0000, 32'h0, 0, h, r);
        do_access(1'b0, 32'h0000_0020, 32'h0, 3, h, r);
        for (int i = 0; i < 16; i++) begin
            a = (i < 8) ? 32'(4 * i) : 32'(32'h20 + 4 * (i - 8));
            do_access(1'b0, a, 32'h0, 0, h, r);
            chk1($sformatf("burst%0d_hit", i), h, 1'b1);
        end

        // Randomised traffic over a small tag/index space to force conflicts.
        for (int n = 0; n < 300; n++) begin
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5)
              | (32'($urandom_range(0, 7)) << 2);
            do_access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), h, r);
            if ($urandom_range(0, 7) == 0) idle_ack();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller in the MEM stage of the pipelined RISC-V core.
- Sits between the EX/MEM pipeline register (address, store data, MemRead/MemWrite) and a slow line-wide backing memory with a req/ack handshake.
- Asserts stall_o on a miss so the pipeline freezes until the line is resident.

Parameters:
NUM_LINES, 32, number of cache lines; power of two; INDEX_W = log2(NUM_LINES)
LINE_BYTES, 32, bytes per line; power of two, at least 8; OFFSET_W = log2(LINE_BYTES), line width LINE_W = 8*LINE_BYTES bits
ADDR_W, 32, byte address width; TAG_W = ADDR_W - INDEX_W - OFFSET_W

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
cpu_req_i  in  1  access request (EXMEM MemRead | MemWrite)
cpu_we_i  in  1  1 = store, 0 = load; valid only when cpu_req_i = 1
cpu_addr_i  in  ADDR_W  byte address (EXMEM ALU result); bits [1:0] ignored
cpu_wdata_i  in  32  store data
cpu_rdata_o  out  32  load data
stall_o  out  1  freeze pipeline
mem_req_o  out  1  backing memory request
mem_we_o  out  1  1 = line write-back, 0 = line fill
mem_addr_o  out  ADDR_W  line-aligned address, offset bits = 0
mem_wdata_o  out  LINE_W  write-back line data
mem_rdata_i  in  LINE_W  fill line data, valid when mem_ack_i = 1
mem_ack_i  in  1  single-cycle completion pulse

Behaviour:
- Address split: tag = addr[ADDR_W-1 : INDEX_W+OFFSET_W], index = addr[INDEX_W+OFFSET_W-1 : OFFSET_W], word = addr[OFFSET_W-1 : 2].
- Storage per line: valid bit, dirty bit, tag, and LINE_W data bits, all held in flops.
- Reset (async, rst_i = 1):
  - All valid and dirty bits cleared; data and tag arrays not cleared.
  - State = IDLE; mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0, cpu_rdata_o = 0, stall_o = 0.
- hit = cpu_req_i & valid[index] & (tag_array[index] == tag), evaluated combinationally.
- State IDLE:
  - cpu_req_i = 0: stall_o = 0; cpu_rdata_o = 0; no state change.
  - Read hit: cpu_rdata_o = selected word, same cycle; stall_o = 0.
  - Write hit: at the clock edge, the selected word is replaced with cpu_wdata_i and dirty[index] is set; stall_o = 0.
  - Miss: stall_o = 1 combinationally in the same cycle.
    - If valid & dirty: go to WRITEBACK.
    - Otherwise: go to ALLOCATE.
- State WRITEBACK:
  - mem_req_o = 1, mem_we_o = 1, mem_addr_o = {old tag, index, 0}, mem_wdata_o = old line; stall_o = 1.
  - On mem_ack_i: dirty[index] cleared, go to ALLOCATE.
- State ALLOCATE:
  - mem_req_o = 1, mem_we_o = 0, mem_addr_o = {cpu tag, index, 0}; stall_o = 1.
  - On mem_ack_i: the line is loaded from mem_rdata_i, valid = 1, dirty = 0, tag is written, go to IDLE.
  - The following IDLE cycle then hits and completes the access (a store sets dirty at that point).
- Memory-side outputs are registered.
  - mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o change only on state entry.
  - They stay stable until mem_ack_i; mem_req_o drops in the cycle after ack.
- Miss latency:
  - Clean miss: 1 + fill-wait + 1 cycles with stall_o high.
  - Dirty miss: a write-back phase is added before the fill.
- Protocol obligations and edge cases:
  - The pipeline holds cpu_req_i, cpu_we_i, cpu_addr_i and cpu_wdata_i constant while stall_o = 1. The controller does not re-sample them and uses the live inputs.
  - mem_ack_i in IDLE is ignored.
  - Back-to-back hits sustain one access per cycle with no bubbles.
  - Conflict miss on the same index with a different tag evicts; same tag, different word is a hit.
  - Reset mid-miss aborts immediately: mem_req_o drops and the dirty line being written back is lost (accepted).

Test Plan:
- Reset, then load 0x0000_0104 with fill line word1 = 0xDEAD_BEEF -> stall_o high; ALLOCATE request to mem_addr_o = 0x0000_0100 with mem_we_o = 0; after ack, next cycle cpu_rdata_o = 0xDEAD_BEEF and stall_o = 0.
- Store 0x1234_5678 to 0x0000_0108 (same line, resident) -> no stall; subsequent load 0x0000_0108 returns 0x1234_5678 with zero stall cycles.
- Load 0x0000_0508 (same index 8, different tag) after the dirty store -> WRITEBACK to 0x0000_0100 with mem_wdata_o word2 = 0x1234_5678, then ALLOCATE to 0x0000_0500; no write-back reissued afterwards.
- Hold mem_ack_i low for 10 cycles during ALLOCATE -> stall_o, mem_req_o and mem_addr_o remain constant throughout; pulse mem_ack_i while idle -> no state or output change.
- Assert rst_i during WRITEBACK -> mem_req_o = 0 and stall_o = 0 immediately; reload of 0x0000_0104 misses (valid cleared).
- 16 consecutive loads to words 0..7 of two resident lines (indices 0 and 1) -> no stall cycle; the matching 16 data values return in order.
